store_buffer: RTL

Write-back buffer between the data-cache stage and the memory arbiter's data port. Queues evicted dirty 256-bit lines with their addresses and drains them to memory in FIFO order over the petition/serviceReady handshake. Data reads are not stalled behind pending writes: a lookup port returns buffered line data for the line currently being missed.

---
 rtl/store_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write-back buffer between the data-cache stage and the memory arbiter's data
// port. Evicted dirty lines are queued with their addresses and drained to
// memory in FIFO order over the petitionMem/serviceReady handshake. A
// combinational lookup port returns buffered line data, so a read miss never
// has to wait for a pending write to reach memory.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; clears all state
//   push_valid    in   cache stage offers an evicted line
//   push_addr     in   byte address of the line (low 5 bits ignored)
//   push_data     in   line contents
//   push_ready    out  buffer can accept a line (registered count < depth)
//   lookup_addr   in   address of a pending read miss
//   lookup_hit    out  some valid entry holds that line (combinational)
//   lookup_data   out  newest matching entry's data, 0 on miss (combinational)
//   petitionMem   out  write request to the arbiter
//   addressMem    out  head entry line address, low 5 bits zero
//   dataWriteMem  out  head entry data
//   weMem         out  write enable, same as petitionMem
//   serviceReady  in   memory completion pulse for the current petition
//   count         out  number of valid entries
//   empty         out  count == 0
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int cache_line_width = 256,
  parameter int addr_width       = 16,
  parameter int depth            = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid,
  input  logic [addr_width-1:0]         push_addr,
  input  logic [cache_line_width-1:0]   push_data,
  output logic                          push_ready,
  input  logic [addr_width-1:0]         lookup_addr,
  output logic                          lookup_hit,
  output logic [cache_line_width-1:0]   lookup_data,
  output logic                          petitionMem,
  output logic [addr_width-1:0]         addressMem,
  output logic [cache_line_width-1:0]   dataWriteMem,
  output logic                          weMem,
  input  logic                          serviceReady,
  output logic [$clog2(depth+1)-1:0]    count,
  output logic                          empty
);

  localparam int offsetBits = 5;
  localparam int tagWidth   = addr_width - offsetBits;
  localparam int ptrWidth   = $clog2(depth);
  localparam int countWidth = $clog2(depth + 1);

  typedef logic [ptrWidth-1:0] ptrT;
  typedef logic [tagWidth-1:0] tagT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } drainStateT;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [depth-1:0]            validQ;
  tagT                         tagMem  [depth];
  logic [cache_line_width-1:0] dataMem [depth];
  ptrT                         headQ;
  ptrT                         tailQ;
  logic [countWidth-1:0]       countQ;
  drainStateT                  stateQ;
  drainStateT                  stateD;

  tagT  pushTag;
  tagT  lookupTag;
  logic pushAccept;
  logic popHead;
  logic coalesceHit;
  ptrT  coalesceIdx;
  logic doAppend;
  ptrT  writeIdx;
  logic lookupMatch;
  ptrT  lookupIdx;

  assign pushTag   = push_addr[addr_width-1:offsetBits];
  assign lookupTag = lookup_addr[addr_width-1:offsetBits];

  // Readiness depends on registered count only, so a pop on the same edge
  // never opens a slot for a push when full.
  assign push_ready = (countQ < countWidth'(depth));
  assign pushAccept = push_valid & push_ready;
  assign popHead    = (stateQ == REQ) & serviceReady;

  // ---------------------------------------------------------------------------
  // Coalesce search. Entries are walked from head toward tail so the last match
  // found is the newest. The head is excluded while its petition is in flight,
  // because memory may already be consuming that data.
  // ---------------------------------------------------------------------------
  always_comb begin
    ptrT idx;
    // NOTE: every signal assigned here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    coalesceHit = 1'b0;
    coalesceIdx = '0;
    idx         = '0;
    for (int i = 0; i < depth; i++) begin
      idx = headQ + ptrT'(i);
      if (validQ[idx] && (tagMem[idx] == pushTag) &&
          !((idx == headQ) && (stateQ == REQ))) begin
        coalesceHit = 1'b1;
        coalesceIdx = idx;
      end
    end
  end

  assign doAppend = pushAccept & ~coalesceHit;
  assign writeIdx = coalesceHit ? coalesceIdx : tailQ;

  // ---------------------------------------------------------------------------
  // Lookup: same head-to-tail walk so the entry nearest the tail wins. Reads
  // only registered state, so a push on the current edge is not yet visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    ptrT idx;
    lookupMatch = 1'b0;
    lookupIdx   = '0;
    idx         = '0;
    for (int i = 0; i < depth; i++) begin
      idx = headQ + ptrT'(i);
      if (validQ[idx] && (tagMem[idx] == lookupTag)) begin
        lookupMatch = 1'b1;
        lookupIdx   = idx;
      end
    end
  end

  assign lookup_hit  = lookupMatch;
  assign lookup_data = lookupMatch ? dataMem[lookupIdx] : '0;

  // ---------------------------------------------------------------------------
  // Control state: valid bits, pointers, count.
  // A pop and an append never target the same slot: that would need
  // head == tail with count at 0 (nothing to pop) or at depth (push refused).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validQ <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (popHead) begin
        validQ[headQ] <= 1'b0;
        headQ         <= headQ + ptrT'(1);
      end
      if (doAppend) begin
        validQ[tailQ] <= 1'b1;
        tailQ         <= tailQ + ptrT'(1);
      end
      countQ <= countQ + countWidth'(doAppend) - countWidth'(popHead);
    end
  end

  // NOTE: the line storage is deliberately not reset; the cleared valid bits
  // hide stale contents from every output.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      tagMem[writeIdx]  <= pushTag;
      dataMem[writeIdx] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (countQ != '0) stateD = REQ;
      REQ:  if (serviceReady) stateD = GAP;
      GAP:  stateD = (countQ != '0) ? REQ : IDLE;
      default: stateD = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-side outputs, all decoded from registered state. The head is never
  // overwritten during REQ, so address and data stay stable for the petition.
  // ---------------------------------------------------------------------------
  assign petitionMem  = (stateQ == REQ);
  assign weMem        = petitionMem;
  assign addressMem   = validQ[headQ] ? {tagMem[headQ], {offsetBits{1'b0}}} : '0;
  assign dataWriteMem = validQ[headQ] ? dataMem[headQ] : '0;
  assign count        = countQ;
  assign empty        = (countQ == '0);

endmodule
